// File: rtl/branch_resolve_unit_if.sv
// Bundle of the prediction-lookup and branch-resolve signals shared between
// the fetch/execute side (master) and the branch resolve unit (slave).
interface branch_resolve_unit_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
);
    logic [XLEN-1:0]  i_pred_pc;
    logic             o_pred_taken;

    logic             i_res_valid;
    logic [XLEN-1:0]  i_res_pc;
    logic [XLEN-1:0]  i_res_r1;
    logic [XLEN-1:0]  i_res_r2;
    logic [2:0]       i_res_func3;
    logic             i_res_pred;
    logic [XLEN-1:0]  i_res_target;

    logic             o_res_valid;
    logic             o_res_taken;
    logic             o_mispredict;
    logic [XLEN-1:0]  o_redirect_pc;
    logic             o_illegal;
    logic [CNT_W-1:0] o_mispred_cnt;

    modport master (
        output i_pred_pc,
        output i_res_valid,
        output i_res_pc,
        output i_res_r1,
        output i_res_r2,
        output i_res_func3,
        output i_res_pred,
        output i_res_target,
        input  o_pred_taken,
        input  o_res_valid,
        input  o_res_taken,
        input  o_mispredict,
        input  o_redirect_pc,
        input  o_illegal,
        input  o_mispred_cnt
    );

    modport slave (
        input  i_pred_pc,
        input  i_res_valid,
        input  i_res_pc,
        input  i_res_r1,
        input  i_res_r2,
        input  i_res_func3,
        input  i_res_pred,
        input  i_res_target,
        output o_pred_taken,
        output o_res_valid,
        output o_res_taken,
        output o_mispredict,
        output o_redirect_pc,
        output o_illegal,
        output o_mispred_cnt
    );
endinterface

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: 2-bit counter BHT for fetch-time prediction, branch
// condition evaluation with one-cycle registered resolution and mispredict stats.
module branch_resolve_unit #(
    parameter int         XLEN      = 32,
    parameter int         BHT_DEPTH = 64,
    parameter logic [1:0] CTR_INIT  = 2'b01,
    parameter int         CNT_W     = 16
) (
    input  logic                i_clk,
    input  logic                i_rst,
    branch_resolve_unit_if.slave bus
);
    localparam int IDX_W = (BHT_DEPTH > 1) ? $clog2(BHT_DEPTH) : 1;

    logic [1:0]       bht [BHT_DEPTH];

    logic [IDX_W-1:0] pred_idx;
    logic [IDX_W-1:0] res_idx;
    logic [1:0]       res_ctr;
    logic [1:0]       res_ctr_next;
    logic             cond_true;
    logic             func3_illegal;
    logic             res_taken;
    logic             res_mispredict;
    logic [XLEN-1:0]  res_next_pc;

    logic             res_valid_q;
    logic             res_taken_q;
    logic             mispredict_q;
    logic [XLEN-1:0]  redirect_pc_q;
    logic             illegal_q;
    logic [CNT_W-1:0] mispred_cnt_q;

    // Word-aligned PCs: bits [1:0] never participate in the index.
    assign pred_idx = bus.i_pred_pc[IDX_W+1:2];
    assign res_idx  = bus.i_res_pc[IDX_W+1:2];

    // Lookup reads the array directly, so a same-cycle update is not yet visible.
    assign bus.o_pred_taken = bht[pred_idx][1];

    always_comb begin
        cond_true = 1'b0;
        case (bus.i_res_func3)
            3'b000:  cond_true = (bus.i_res_r1 == bus.i_res_r2);
            3'b001:  cond_true = (bus.i_res_r1 != bus.i_res_r2);
            3'b100:  cond_true = ($signed(bus.i_res_r1) <  $signed(bus.i_res_r2));
            3'b101:  cond_true = ($signed(bus.i_res_r1) >= $signed(bus.i_res_r2));
            3'b110:  cond_true = (bus.i_res_r1 <  bus.i_res_r2);
            3'b111:  cond_true = (bus.i_res_r1 >= bus.i_res_r2);
            default: cond_true = 1'b0;
        endcase
    end

    assign func3_illegal  = (bus.i_res_func3[2:1] == 2'b01);
    assign res_taken      = cond_true & ~func3_illegal;
    assign res_mispredict = res_taken ^ bus.i_res_pred;
    assign res_next_pc    = res_taken ? bus.i_res_target
                                      : bus.i_res_pc + {{(XLEN-3){1'b0}}, 3'b100};

    always_comb begin
        res_ctr      = bht[res_idx];
        res_ctr_next = res_ctr;
        if (res_taken) begin
            if (res_ctr != 2'b11) begin
                res_ctr_next = res_ctr + 2'd1;
            end
        end else begin
            if (res_ctr != 2'b00) begin
                res_ctr_next = res_ctr - 2'd1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                bht[i] <= CTR_INIT;
            end
        end else if (bus.i_res_valid && !func3_illegal) begin
            bht[res_idx] <= res_ctr_next;
        end
    end

    // Redirect PC is only refreshed by valid requests; idle cycles hold it.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            res_valid_q   <= 1'b0;
            res_taken_q   <= 1'b0;
            mispredict_q  <= 1'b0;
            illegal_q     <= 1'b0;
            redirect_pc_q <= '0;
            mispred_cnt_q <= '0;
        end else begin
            res_valid_q  <= bus.i_res_valid;
            res_taken_q  <= bus.i_res_valid & res_taken;
            mispredict_q <= bus.i_res_valid & res_mispredict;
            illegal_q    <= bus.i_res_valid & func3_illegal;
            if (bus.i_res_valid) begin
                redirect_pc_q <= res_next_pc;
            end
            if (bus.i_res_valid && res_mispredict && (mispred_cnt_q != {CNT_W{1'b1}})) begin
                mispred_cnt_q <= mispred_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign bus.o_res_valid   = res_valid_q;
    assign bus.o_res_taken   = res_taken_q;
    assign bus.o_mispredict  = mispredict_q;
    assign bus.o_illegal     = illegal_q;
    assign bus.o_redirect_pc = redirect_pc_q;
    assign bus.o_mispred_cnt = mispred_cnt_q;
endmodule
